rom_dl_sequencer: RTL and testbench

Download-bus generator for the ROM and PROM download port. It accepts 32-bit words from the loader bridge over a valid/ready handshake and serializes them big-endian into byte writes. Each write is driven on `DLADDR`/`DLDATA`/`DLWR`, starting at address 0x00000, until the image length is reached. Its outputs connect directly to the `I_DLADDR`/`I_DLDATA`/`I_DLWR` inputs of every ROM block, and it runs on the same clock as `I_DLCLK`.

---
 rtl/rom_dl_sequencer.sv | 154 +++++++++++++++
 tb/tb_rom_dl_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: turns 32-bit loader words into big-endian byte writes on
// the shared ROM/PROM download bus (DLADDR/DLDATA/DLWR), address 0 upward,
// until TOTAL_BYTES bytes have been written.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// S_IDLE    | after reset; bus quiet, READY=0, waiting for I_START
// S_WAIT_WORD | READY=1, waiting for a word from the bridge
// S_STROBE  | DLWR=1 with address/data stable, held WR_HOLD cycles
// S_GAP     | one DLWR=0 cycle; address counter advances at its end
// S_DONE    | image complete; words still accepted and dropped

module rom_dl_sequencer #(
  parameter int unsigned TOTAL_BYTES = 81920,
  parameter int unsigned WR_HOLD     = 2
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_START,
  input  logic [31:0] I_WORD,
  input  logic        I_WORD_VALID,
  output logic        O_WORD_READY,
  output logic [16:0] O_DLADDR,
  output logic [7:0]  O_DLDATA,
  output logic        O_DLWR,
  output logic        O_BUSY,
  output logic        O_DONE
);

  // Address of the final byte; the counter is compared against this before
  // it would increment, so it never has to wrap past 0x1FFFF.
  localparam logic [16:0] LAST_ADDR = 17'(TOTAL_BYTES - 1);

  // Strobe timer is a down-counter loaded with WR_HOLD-1; terminal count 0
  // ends the strobe.
  localparam int unsigned  HW        = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(WR_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_STROBE,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state;
  logic [16:0]     addr_cnt;
  logic [31:0]     word_q;
  logic [1:0]      byte_idx;
  logic [HW-1:0]   hold_cnt;

  // Big-endian byte pick: index 0 is the most significant byte.
  function automatic logic [7:0] pick_byte(input logic [31:0] w,
                                           input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Sequencer FSM; every output is a register updated here. I_START wins over
  // everything else, including a handshake in the same cycle, and drops any
  // word in flight.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state        <= S_IDLE;
      addr_cnt     <= '0;
      word_q       <= '0;
      byte_idx     <= '0;
      hold_cnt     <= '0;
      O_WORD_READY <= 1'b0;
      O_DLADDR     <= '0;
      O_DLDATA     <= '0;
      O_DLWR       <= 1'b0;
      O_BUSY       <= 1'b0;
      O_DONE       <= 1'b0;
    end else if (I_START) begin
      state        <= S_WAIT_WORD;
      addr_cnt     <= '0;
      word_q       <= '0;
      byte_idx     <= '0;
      hold_cnt     <= '0;
      O_WORD_READY <= 1'b1;
      O_DLWR       <= 1'b0;
      O_BUSY       <= 1'b1;
      O_DONE       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
        end

        S_WAIT_WORD: begin
          if (I_WORD_VALID && O_WORD_READY) begin
            word_q       <= I_WORD;
            byte_idx     <= 2'd0;
            hold_cnt     <= HOLD_LOAD;
            O_WORD_READY <= 1'b0;
            O_DLWR       <= 1'b1;
            O_DLADDR     <= addr_cnt;
            O_DLDATA     <= I_WORD[31:24];
            state        <= S_STROBE;
          end
        end

        S_STROBE: begin
          if (hold_cnt == '0) begin
            O_DLWR <= 1'b0;
            state  <= S_GAP;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        S_GAP: begin
          if (addr_cnt == LAST_ADDR) begin
            // Image complete; any unused bytes of the last word are dropped.
            O_BUSY       <= 1'b0;
            O_DONE       <= 1'b1;
            O_WORD_READY <= 1'b1;
            state        <= S_DONE;
          end else begin
            addr_cnt <= addr_cnt + 17'd1;
            if (byte_idx == 2'd3) begin
              O_WORD_READY <= 1'b1;
              state        <= S_WAIT_WORD;
            end else begin
              // Address and data change only together with the rising DLWR.
              byte_idx <= byte_idx + 2'd1;
              hold_cnt <= HOLD_LOAD;
              O_DLWR   <= 1'b1;
              O_DLADDR <= addr_cnt + 17'd1;
              O_DLDATA <= pick_byte(word_q, byte_idx + 2'd1);
              state    <= S_STROBE;
            end
          end
        end

        S_DONE: begin
          // READY stays high so the bridge drains; accepted words are ignored.
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Bench for rom_dl_sequencer: two instances (a 40-byte image with WR_HOLD=2
// and a 6-byte image with WR_HOLD=1) driven with random words and compared
// against a byte-stream model of the download bus.
module tb_rom_dl_sequencer;

  localparam int A_TOTAL = 40;
  localparam int A_HOLD  = 2;
  localparam int B_TOTAL = 6;
  localparam int B_HOLD  = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, valid_a = 1'b0;
  logic [31:0] word_a  = '0;
  logic        ready_a, dlwr_a, busy_a, done_a;
  logic [16:0] dladdr_a;
  logic [7:0]  dldata_a;

  logic        start_b = 1'b0, valid_b = 1'b0;
  logic [31:0] word_b  = '0;
  logic        ready_b, dlwr_b, busy_b, done_b;
  logic [16:0] dladdr_b;
  logic [7:0]  dldata_b;

  rom_dl_sequencer #(.TOTAL_BYTES(A_TOTAL), .WR_HOLD(A_HOLD)) dut_a (
    .I_CLK(clk), .I_RESET(rst), .I_START(start_a), .I_WORD(word_a),
    .I_WORD_VALID(valid_a), .O_WORD_READY(ready_a), .O_DLADDR(dladdr_a),
    .O_DLDATA(dldata_a), .O_DLWR(dlwr_a), .O_BUSY(busy_a), .O_DONE(done_a)
  );

  rom_dl_sequencer #(.TOTAL_BYTES(B_TOTAL), .WR_HOLD(B_HOLD)) dut_b (
    .I_CLK(clk), .I_RESET(rst), .I_START(start_b), .I_WORD(word_b),
    .I_WORD_VALID(valid_b), .O_WORD_READY(ready_b), .O_DLADDR(dladdr_b),
    .O_DLDATA(dldata_b), .O_DLWR(dlwr_b), .O_BUSY(busy_b), .O_DONE(done_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observed strobes and expected byte writes.
  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    int          len;
    int          gap;
    bit          stable;
  } wr_t;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
  } exp_t;

  wr_t  mon_a[$], mon_b[$];
  exp_t exp_a[$], exp_b[$];
  int   next_a = 0, next_b = 0;

  wr_t cur_a, cur_b;
  bit  prev_a = 0, prev_b = 0;
  int  gap_a = 0, gap_b = 0;

  // Bus monitor, instance A: one record per strobe (length, stability, gap).
  always @(negedge clk) begin
    if (rst) begin
      prev_a = 0;
      gap_a  = 0;
    end else begin
      if (dlwr_a && !prev_a) begin
        cur_a.addr = dladdr_a; cur_a.data = dldata_a;
        cur_a.len = 1; cur_a.gap = gap_a; cur_a.stable = 1;
      end else if (dlwr_a) begin
        cur_a.len++;
        if (dladdr_a != cur_a.addr || dldata_a != cur_a.data) cur_a.stable = 0;
      end else if (prev_a) begin
        if (dladdr_a != cur_a.addr || dldata_a != cur_a.data) cur_a.stable = 0;
        mon_a.push_back(cur_a);
        gap_a = 1;
      end else begin
        gap_a++;
      end
      prev_a = dlwr_a;
    end
  end

  // Bus monitor, instance B.
  always @(negedge clk) begin
    if (rst) begin
      prev_b = 0;
      gap_b  = 0;
    end else begin
      if (dlwr_b && !prev_b) begin
        cur_b.addr = dladdr_b; cur_b.data = dldata_b;
        cur_b.len = 1; cur_b.gap = gap_b; cur_b.stable = 1;
      end else if (dlwr_b) begin
        cur_b.len++;
        if (dladdr_b != cur_b.addr || dldata_b != cur_b.data) cur_b.stable = 0;
      end else if (prev_b) begin
        if (dladdr_b != cur_b.addr || dldata_b != cur_b.data) cur_b.stable = 0;
        mon_b.push_back(cur_b);
        gap_b = 1;
      end else begin
        gap_b++;
      end
      prev_b = dlwr_b;
    end
  end

  // Reference: a word contributes its bytes MSB first at consecutive
  // addresses, and nothing at or beyond the image length.
  task automatic model_word(input int which, input logic [31:0] w);
    exp_t e;
    for (int b = 0; b < 4; b++) begin
      e.data = 8'(w >> (8 * (3 - b)));
      if (which == 0 && next_a < A_TOTAL) begin
        e.addr = 17'(next_a); exp_a.push_back(e); next_a++;
      end else if (which == 1 && next_b < B_TOTAL) begin
        e.addr = 17'(next_b); exp_b.push_back(e); next_b++;
      end
    end
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) begin start_a = 1; next_a = 0; end
    else begin start_b = 1; next_b = 0; end
    @(negedge clk);
    start_a = 0;
    start_b = 0;
  endtask

  task automatic send(input int which, input logic [31:0] w, input int delay);
    int n;
    repeat (delay) @(negedge clk);
    model_word(which, w);
    n = 0;
    if (which == 0) begin
      word_a = w; valid_a = 1;
      while (!ready_a && n < 300) begin @(negedge clk); n++; end
    end else begin
      word_b = w; valid_b = 1;
      while (!ready_b && n < 300) begin @(negedge clk); n++; end
    end
    check_eq("send_ready", n < 300, 1);
    @(negedge clk);
    valid_a = 0;
    valid_b = 0;
  endtask

  task automatic wait_done(input int which, input int limit);
    int n;
    n = 0;
    while (((which == 0) ? !done_a : !done_b) && n < limit) begin
      @(negedge clk); n++;
    end
    check_eq("done_wait", n < limit, 1);
  endtask

  task automatic drain(input int which, input int hold);
    wr_t  m[$];
    exp_t x[$];
    int   n;
    if (which == 0) begin
      m = mon_a; x = exp_a; mon_a.delete(); exp_a.delete();
    end else begin
      m = mon_b; x = exp_b; mon_b.delete(); exp_b.delete();
    end
    check_eq("n_writes", m.size(), x.size());
    n = (m.size() < x.size()) ? m.size() : x.size();
    for (int i = 0; i < n; i++) begin
      check_eq("wr_addr", m[i].addr, x[i].addr);
      check_eq("wr_data", m[i].data, x[i].data);
      check_eq("wr_len", m[i].len, hold);
      check_eq("wr_stable", m[i].stable, 1);
      if (x[i].addr[1:0] != 2'd0) check_eq("wr_gap", m[i].gap, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok;

    #1 rst = 1;
    #1;
    check_eq("rst_out_a", {dladdr_a, dldata_a, dlwr_a, ready_a, busy_a, done_a}, 0);
    check_eq("rst_out_b", {dladdr_b, dldata_b, dlwr_b, ready_b, busy_b, done_b}, 0);
    repeat (3) @(negedge clk);
    #2 rst = 0;
    repeat (3) @(negedge clk);
    check_eq("idle_ready", ready_a, 0);
    check_eq("idle_busy", busy_a, 0);

    pulse_start(0);
    check_eq("start_ready", ready_a, 1);
    check_eq("start_busy", busy_a, 1);
    check_eq("start_done", done_a, 0);

    send(0, 32'h11223344, 0);
    n = 0;
    while (!ready_a && n < 100) begin @(negedge clk); n++; end
    check_eq("ready_return", n, 12);
    drain(0, A_HOLD);

    ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ready_a) ok = 0;
    end
    check_eq("stall_ready", ok, 1);
    check_eq("stall_nowr", mon_a.size(), 0);

    for (int i = 0; i < 9; i++) send(0, $urandom, $urandom_range(0, 3));
    wait_done(0, 500);
    repeat (3) @(negedge clk);
    drain(0, A_HOLD);
    check_eq("full_done", done_a, 1);
    check_eq("full_busy", busy_a, 0);
    check_eq("full_last_addr", dladdr_a, A_TOTAL - 1);

    send(0, $urandom, 0);
    repeat (10) @(negedge clk);
    drain(0, A_HOLD);
    check_eq("extra_ready", ready_a, 1);
    check_eq("extra_done", done_a, 1);

    pulse_start(0);
    check_eq("restart_done", done_a, 0);
    check_eq("restart_busy", busy_a, 1);
    send(0, $urandom, 0);
    n = 0;
    while (!(dlwr_a && dladdr_a == 17'd2) && n < 100) begin @(negedge clk); n++; end
    check_eq("abort_found", n < 100, 1);
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    check_eq("abort_dlwr", dlwr_a, 0);
    check_eq("abort_ready", ready_a, 1);
    repeat (2) @(negedge clk);
    mon_a.delete();
    exp_a.delete();
    next_a = 0;

    start_a = 1; valid_a = 1; word_a = $urandom;
    @(negedge clk);
    start_a = 0; valid_a = 0;
    check_eq("prio_ready", ready_a, 1);
    repeat (8) @(negedge clk);
    check_eq("prio_nowr", mon_a.size(), 0);

    for (int i = 0; i < 10; i++) send(0, $urandom, $urandom_range(0, 2));
    wait_done(0, 500);
    repeat (3) @(negedge clk);
    drain(0, A_HOLD);
    check_eq("run2_done", done_a, 1);
    check_eq("run2_last_addr", dladdr_a, A_TOTAL - 1);

    pulse_start(0);
    send(0, $urandom | 32'h8000_0000, 0);
    n = 0;
    while (!dlwr_a && n < 50) begin @(negedge clk); n++; end
    check_eq("rst_strobe_found", n < 50, 1);
    #2 rst = 1;
    #1;
    check_eq("async_rst", {dladdr_a, dldata_a, dlwr_a, ready_a, busy_a, done_a}, 0);
    @(negedge clk);
    #2 rst = 0;
    mon_a.delete();
    exp_a.delete();
    repeat (5) @(negedge clk);
    check_eq("post_rst_ready", ready_a, 0);
    check_eq("post_rst_busy", busy_a, 0);
    check_eq("post_rst_nowr", mon_a.size(), 0);
    pulse_start(0);
    check_eq("post_rst_start", ready_a, 1);

    pulse_start(1);
    send(1, 32'hA0A1A2A3, 0);
    send(1, 32'hB0B1B2B3, 0);
    wait_done(1, 200);
    repeat (3) @(negedge clk);
    drain(1, B_HOLD);
    check_eq("part_addr", dladdr_b, 5);
    check_eq("part_data", dldata_b, 8'hB1);
    check_eq("part_done", done_b, 1);
    check_eq("part_busy", busy_b, 0);
    send(1, $urandom, 0);
    repeat (6) @(negedge clk);
    drain(1, B_HOLD);
    check_eq("part_extra_ready", ready_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
